// File: rtl/fc_argmax_classifier.sv
// Argmax over one frame of NUMBER_CLASS IEEE-754 single-precision values arriving serially.
// Define ARGMAX_TIE_LAST_EN to make ties resolve to the highest class index (default: lowest).
module fc_argmax_classifier #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUMBER_CLASS = 10,
  parameter int INDEX_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_clear,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic [DATA_WIDTH-1:0]  o_max,
  output logic                   o_valid,
  output logic                   o_nan,
  output logic                   o_busy
);

  localparam int CW = $clog2(NUMBER_CLASS + 1);

`ifdef ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                 state;
  logic [CW-1:0]          count;
  logic [DATA_WIDTH-1:0]  run_max;
  logic [INDEX_WIDTH-1:0] run_idx;
  logic                   nan_seen;

  logic                   cand_wins;
  logic                   last_beat;
  logic [DATA_WIDTH-1:0]  win_max;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic                   win_nan;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Sign-magnitude ordering; +0 and -0 are treated as equal.
  function automatic logic wins(input logic [DATA_WIDTH-1:0] cand,
                                input logic [DATA_WIDTH-1:0] cur);
    logic [30:0] mc, mr;
    logic gt, eq, both_zero;
    mc        = cand[30:0];
    mr        = cur[30:0];
    both_zero = (mc == 31'd0) && (mr == 31'd0);
    case ({cand[31], cur[31]})
      2'b00:   begin gt = (mc > mr); eq = (mc == mr); end
      2'b11:   begin gt = (mc < mr); eq = (mc == mr); end
      2'b01:   begin gt = !both_zero; eq = both_zero; end
      default: begin gt = 1'b0;       eq = both_zero; end
    endcase
    if (is_nan(cand)) return 1'b0;
    if (is_nan(cur))  return 1'b1;
    return gt | (TIE_LAST & eq);
  endfunction

  always_comb begin
    cand_wins = wins(i_data, run_max);
    win_max   = cand_wins ? i_data : run_max;
    win_idx   = cand_wins ? INDEX_WIDTH'(count) : run_idx;
    win_nan   = nan_seen | is_nan(i_data);
    last_beat = (count == CW'(NUMBER_CLASS - 1));
  end

  assign o_busy = (state == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      nan_seen <= 1'b0;
      o_index  <= '0;
      o_max    <= '0;
      o_valid  <= 1'b0;
      o_nan    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_clear) begin
        state <= IDLE;
        count <= '0;
      end else if (i_valid) begin
        case (state)
          IDLE: begin
            if (NUMBER_CLASS == 1) begin
              o_max   <= i_data;
              o_index <= '0;
              o_nan   <= is_nan(i_data);
              o_valid <= 1'b1;
            end else begin
              run_max  <= i_data;
              run_idx  <= '0;
              nan_seen <= is_nan(i_data);
              count    <= CW'(1);
              state    <= ACCUM;
            end
          end
          ACCUM: begin
            if (last_beat) begin
              o_max   <= win_max;
              o_index <= win_idx;
              o_nan   <= win_nan;
              o_valid <= 1'b1;
              count   <= '0;
              state   <= IDLE;
            end else begin
              run_max  <= win_max;
              run_idx  <= win_idx;
              nan_seen <= win_nan;
              count    <= count + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Directed-vector bench for fc_argmax_classifier with hand-computed winners.
module tb_fc_argmax_classifier;

  typedef logic [31:0] frame_t [10];

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_clear;
  logic [3:0]  o_index;
  logic [31:0] o_max;
  logic        o_valid;
  logic        o_nan;
  logic        o_busy;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int p_cyc[$];
  int p_idx[$];

  fc_argmax_classifier #(.DATA_WIDTH(32), .NUMBER_CLASS(10), .INDEX_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data), .i_clear(i_clear),
    .o_index(o_index), .o_max(o_max), .o_valid(o_valid), .o_nan(o_nan), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      p_cyc.push_back(cyc);
      p_idx.push_back(int'(o_index));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one frame starting at a negedge; returns at the negedge where the emit should be visible.
  task automatic send_frame(input frame_t f, input bit gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = $urandom_range(0, 3);
        i_valid = 1'b0;
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          chk("busy_gap", 32'(o_busy), 32'd1);
        end
      end
      i_valid = 1'b1;
      i_data  = f[i];
      @(negedge clk);
      if (gaps && i < 9) chk("busy_beat", 32'(o_busy), 32'd1);
    end
    i_valid = 1'b0;
    #1;
  endtask

  task automatic expect_result(input string tag, input int n0, input logic [3:0] idx,
                               input logic [31:0] mx, input logic nan);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_pulses"}, 32'(p_idx.size()), 32'(n0 + 1));
    chk({tag, "_index"}, 32'(o_index), 32'(idx));
    chk({tag, "_max"}, o_max, mx);
    chk({tag, "_nan"}, 32'(o_nan), 32'(nan));
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_single"}, 32'(p_idx.size()), 32'(n0 + 1));
    chk({tag, "_hold"}, 32'(o_index), 32'(idx));
  endtask

  frame_t f;
  int n0;

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_clear = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_index", 32'(o_index), 32'd0);
    chk("rst_max", o_max, 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_nan", 32'(o_nan), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0.0 .. 9.0
    f = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
    n0 = p_idx.size();
    send_frame(f, 1'b0);
    expect_result("ramp", n0, 4'd9, 32'h41100000, 1'b0);

    // All negative with gaps: -1.0 at class 3
    f = '{default: 32'hC0400000};
    f[3] = 32'hBF800000;
    n0 = p_idx.size();
    @(negedge clk);
    send_frame(f, 1'b1);
    expect_result("neg", n0, 4'd3, 32'hBF800000, 1'b0);

    // Tie 2.0 at classes 2 and 7
    f = '{default: 32'h3F000000};
    f[2] = 32'h40000000;
    f[7] = 32'h40000000;
    n0 = p_idx.size();
    send_frame(f, 1'b0);
`ifdef ARGMAX_TIE_LAST_EN
    expect_result("tie", n0, 4'd7, 32'h40000000, 1'b0);
`else
    expect_result("tie", n0, 4'd2, 32'h40000000, 1'b0);
`endif

    // -0 then +0s
    f = '{default: 32'h00000000};
    f[0] = 32'h80000000;
    n0 = p_idx.size();
    send_frame(f, 1'b0);
`ifdef ARGMAX_TIE_LAST_EN
    expect_result("zero", n0, 4'd9, 32'h00000000, 1'b0);
`else
    expect_result("zero", n0, 4'd0, 32'h80000000, 1'b0);
`endif

    // NaN first, 1.0 at class 5, -1.0 elsewhere
    f = '{default: 32'hBF800000};
    f[0] = 32'h7FC00000;
    f[5] = 32'h3F800000;
    n0 = p_idx.size();
    send_frame(f, 1'b0);
    expect_result("nan", n0, 4'd5, 32'h3F800000, 1'b1);

    // Back-to-back: A wins at 4 (100.0), B wins at 1 (3.0)
    n0 = p_idx.size();
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1;
      if (i < 10) i_data = (i == 4) ? 32'h42C80000 : 32'h3F800000;
      else        i_data = (i == 11) ? 32'h40400000 : 32'h3F800000;
      @(negedge clk);
    end
    i_valid = 1'b0;
    #1;
    chk("b2b_pulses", 32'(p_idx.size()), 32'(n0 + 2));
    if (p_idx.size() >= n0 + 2) begin
      chk("b2b_idx_a", 32'(p_idx[n0]), 32'd4);
      chk("b2b_idx_b", 32'(p_idx[n0+1]), 32'd1);
      chk("b2b_spacing", 32'(p_cyc[n0+1] - p_cyc[n0]), 32'd10);
    end
    chk("b2b_max", o_max, 32'h40400000);
    repeat (2) @(negedge clk);

    // 5 beats, clear together with a beat, then a fresh frame (5.0 at class 6)
    n0 = p_idx.size();
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = 32'h44000000;
      @(negedge clk);
    end
    i_clear = 1'b1;
    i_data  = 32'h7F000000;
    @(negedge clk);
    i_clear = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("clr_busy", 32'(o_busy), 32'd0);
    chk("clr_no_pulse", 32'(p_idx.size()), 32'(n0));
    @(negedge clk);
    f = '{default: 32'h3F800000};
    f[6] = 32'h40A00000;
    send_frame(f, 1'b0);
    expect_result("clr", n0, 4'd6, 32'h40A00000, 1'b0);

    // Asynchronous reset after 6 beats
    n0 = p_idx.size();
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      i_data  = 32'h45000000;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_index", 32'(o_index), 32'd0);
    chk("arst_max", o_max, 32'd0);
    chk("arst_nan", 32'(o_nan), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_pulse", 32'(p_idx.size()), 32'(n0));
    f = '{default: 32'hC0000000};
    f[8] = 32'h41000000;
    send_frame(f, 1'b0);
    expect_result("post_rst", n0, 4'd8, 32'h41000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
